// File: rtl/mood_pkg.sv
// Shared definitions for the mood regulator: emotion bit positions,
// neurotransmitter slot order, stimulus bit positions, development stage
// codes, persistence FSM state encoding and the dominant-emotion priority table.
package mood_pkg;

  // Number of emotions classified and filtered
  localparam int unsigned N_EMO = 8;

  // Bit positions within emotional_state
  localparam int unsigned EMO_HAPPY     = 0;
  localparam int unsigned EMO_EXCITED   = 1;
  localparam int unsigned EMO_STRESSED  = 2;
  localparam int unsigned EMO_NERVOUS   = 3;
  localparam int unsigned EMO_BORED     = 4;
  localparam int unsigned EMO_ANGRY     = 5;
  localparam int unsigned EMO_CALM      = 6;
  localparam int unsigned EMO_APATHETIC = 7;

  // Neurotransmitter slots, counted from the LSB end of the packed level bus
  localparam int unsigned N_NT    = 5;
  localparam int unsigned NT_CORT = 0;
  localparam int unsigned NT_DOP  = 1;
  localparam int unsigned NT_GABA = 2;
  localparam int unsigned NT_NE   = 3;
  localparam int unsigned NT_SER  = 4;

  // Control bit positions
  localparam int unsigned ACT_ASLEEP    = 0;
  localparam int unsigned STIM_STARVING = 12;
  localparam int unsigned STIM_TIRED    = 13;

  // Development stage codes
  typedef enum logic [1:0] {
    STAGE_BABY  = 2'd0,
    STAGE_CHILD = 2'd1,
    STAGE_TEEN  = 2'd2,
    STAGE_ADULT = 2'd3
  } stage_e;

  // Persistence filter states; the output bit is high in ON and FALLING
  typedef enum logic [1:0] {
    PERSIST_OFF     = 2'd0,
    PERSIST_RISING  = 2'd1,
    PERSIST_ON      = 2'd2,
    PERSIST_FALLING = 2'd3
  } persist_state_e;

  // Dominant-emotion order, highest priority first
  localparam logic [2:0] PRIO_ORDER [N_EMO] = '{
    3'd7, 3'd2, 3'd5, 3'd3, 3'd1, 3'd0, 3'd6, 3'd4
  };

  // Index of the highest-priority set bit; 0 when nothing is set.
  // Walks the table from lowest to highest priority so the last hit wins.
  function automatic logic [2:0] prio_encode(input logic [N_EMO-1:0] st);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_EMO - 1; i >= 0; i--) begin
      if (st[PRIO_ORDER[i]]) begin
        idx = PRIO_ORDER[i];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/emotion_persist.sv
// Asymmetric persistence filter for a single emotion. A raw term must be
// seen high on DWELL consecutive sample ticks before the output asserts,
// and low on RELEASE consecutive ticks before it deasserts. A single
// opposite sample during either run aborts it. clear (sleep) returns the
// filter to OFF on the next edge regardless of sample_en.
module emotion_persist
  import mood_pkg::*;
#(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned RELEASE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic clear,
  input  logic raw_in,
  output logic state_out
);

  localparam int unsigned CNT_TOP = (DWELL > RELEASE) ? DWELL : RELEASE;
  localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] DWELL_CNT   = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] RELEASE_CNT = CNT_W'(RELEASE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  localparam logic [1:0] S_OFF     = PERSIST_OFF;
  localparam logic [1:0] S_RISING  = PERSIST_RISING;
  localparam logic [1:0] S_ON      = PERSIST_ON;
  localparam logic [1:0] S_FALLING = PERSIST_FALLING;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             out_reg, out_next;

  // Saturating increment: the counter can never wrap back to a small value
  assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_ONE;

  // Next-state and counter logic; sleep clear overrides sampling
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (clear) begin
      state_next = S_OFF;
      cnt_next   = '0;
    end else if (sample_en) begin
      case (state_reg)
        S_OFF: begin
          if (raw_in) begin
            if (DWELL == 1) begin
              state_next = S_ON;
              cnt_next   = '0;
            end else begin
              state_next = S_RISING;
              cnt_next   = CNT_ONE;
            end
          end
        end
        S_RISING: begin
          if (!raw_in) begin
            state_next = S_OFF;
            cnt_next   = '0;
          end else if (cnt_inc == DWELL_CNT) begin
            state_next = S_ON;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        S_ON: begin
          if (!raw_in) begin
            if (RELEASE == 1) begin
              state_next = S_OFF;
              cnt_next   = '0;
            end else begin
              state_next = S_FALLING;
              cnt_next   = CNT_ONE;
            end
          end
        end
        S_FALLING: begin
          if (raw_in) begin
            state_next = S_ON;
            cnt_next   = '0;
          end else if (cnt_inc == RELEASE_CNT) begin
            state_next = S_OFF;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = S_OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // The filtered bit follows the state being entered, so it moves on the same edge
  assign out_next = (state_next == S_ON) || (state_next == S_FALLING);

  // State, counter and filtered output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_OFF;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  assign state_out = out_reg;

endmodule

// File: rtl/mood_regulator.sv
// Mood regulator: classifies five neurotransmitter levels plus sleep,
// stimuli and development stage into eight raw emotions, debounces each
// through an emotion_persist filter, and reports the filtered set, a
// dominant emotion, a valid flag and a one-cycle change strobe.
// Optional feature macro: MOOD_PRIORITY_EN (registered priority encode
// drives dominant; otherwise dominant is held at 0).
module mood_regulator
  import mood_pkg::*;
#(
  parameter int unsigned NT_W    = 2,
  parameter int unsigned DWELL   = 4,
  parameter int unsigned RELEASE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [7:0]          action,
  input  logic [5*NT_W-1:0]   neurotransmitter_level,
  input  logic [15:0]         stimuli,
  input  logic [1:0]          development_stage,
  output logic [7:0]          emotional_state,
  output logic [2:0]          dominant,
  output logic                dominant_valid,
  output logic                state_change
);

  logic [N_NT-1:0]  nt_hi;
  logic [N_NT-1:0]  nt_max;
  logic [N_NT-1:0]  nt_zero;
  logic [N_EMO-1:0] raw_vec;
  logic [N_EMO-1:0] filt_state;
  logic [N_EMO-1:0] prev_state_reg;
  logic             asleep;
  logic             starving;
  logic             tired;
  logic             is_baby;
  logic             is_teen;
  logic             unused_inputs;

  assign asleep   = action[ACT_ASLEEP];
  assign starving = stimuli[STIM_STARVING];
  assign tired    = stimuli[STIM_TIRED];
  assign is_baby  = (development_stage == STAGE_BABY);
  assign is_teen  = (development_stage == STAGE_TEEN);

  // Remaining action and stimulus bits belong to other consumers of these buses
  assign unused_inputs = ^{action[7:1], stimuli[15:14], stimuli[11:0]};

  // Level classes for each neurotransmitter slot; HI is the MSB alone so
  // wider levels keep the 2-bit meaning (upper half of the range)
  genvar gi;
  generate
    for (gi = 0; gi < N_NT; gi++) begin : g_nt
      assign nt_hi[gi]   = neurotransmitter_level[gi*NT_W + NT_W - 1];
      assign nt_max[gi]  = &neurotransmitter_level[gi*NT_W +: NT_W];
      assign nt_zero[gi] = ~|neurotransmitter_level[gi*NT_W +: NT_W];
    end
  endgenerate

  // Raw emotion terms; nothing is felt while asleep
  always_comb begin
    raw_vec = '0;
    if (!asleep) begin
      raw_vec[EMO_HAPPY]     = !nt_hi[NT_NE] && !nt_hi[NT_CORT] &&
                               (nt_hi[NT_SER] || nt_hi[NT_DOP] || nt_hi[NT_GABA]);
      raw_vec[EMO_EXCITED]   = nt_hi[NT_NE] && !nt_hi[NT_CORT] &&
                               nt_hi[NT_DOP] && !nt_hi[NT_GABA];
      raw_vec[EMO_STRESSED]  = nt_max[NT_NE] && !nt_zero[NT_CORT] &&
                               (!nt_hi[NT_SER] || !nt_hi[NT_GABA] || is_baby) &&
                               !(starving && tired);
      raw_vec[EMO_NERVOUS]   = nt_hi[NT_NE] && !nt_max[NT_NE] && !nt_zero[NT_CORT] &&
                               (!nt_hi[NT_GABA] || !nt_hi[NT_SER] || is_baby);
      raw_vec[EMO_BORED]     = !nt_hi[NT_NE] && !nt_hi[NT_CORT] &&
                               ((!nt_hi[NT_DOP] && nt_hi[NT_SER]) || tired);
      raw_vec[EMO_ANGRY]     = nt_hi[NT_NE] && !nt_hi[NT_DOP] &&
                               (!nt_hi[NT_GABA] || !nt_hi[NT_SER] || is_teen);
      raw_vec[EMO_CALM]      = !nt_hi[NT_NE] && !nt_hi[NT_CORT] && !nt_hi[NT_DOP] &&
                               (nt_hi[NT_GABA] || nt_hi[NT_SER]);
      raw_vec[EMO_APATHETIC] = nt_hi[NT_CORT] && nt_zero[NT_SER] && starving && tired;
    end
  end

  // One persistence filter per emotion
  generate
    for (gi = 0; gi < N_EMO; gi++) begin : g_persist
      emotion_persist #(
        .DWELL   (DWELL),
        .RELEASE (RELEASE)
      ) u_persist (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .clear     (asleep),
        .raw_in    (raw_vec[gi]),
        .state_out (filt_state[gi])
      );
    end
  endgenerate

  assign emotional_state = filt_state;
  assign dominant_valid  = |filt_state;

  // Copy of the filtered set from the previous cycle for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state_reg <= '0;
    end else begin
      prev_state_reg <= filt_state;
    end
  end

  // Both operands are flops, so this is high for exactly the cycle that
  // follows any edge which altered the filtered set (sleep clears included)
  assign state_change = |(filt_state ^ prev_state_reg);

`ifdef MOOD_PRIORITY_EN
  logic [2:0] dominant_reg;

  // Registered priority encode of the filtered set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dominant_reg <= 3'd0;
    end else begin
      dominant_reg <= prio_encode(filt_state);
    end
  end

  assign dominant = dominant_reg;
`else
  assign dominant = 3'd0;
`endif

endmodule

// File: tb/tb_mood_regulator.sv
// Self-checking bench for mood_regulator. A table of classification
// vectors is replayed through the default DUT (NT_W=2, DWELL=4, RELEASE=2)
// via a scoreboard queue; hand sequences cover reset, glitch rejection,
// sleep override and a wide-level instance (NT_W=3, DWELL=1, RELEASE=1).
module tb_mood_regulator;

  localparam int DWELL = 4;

`ifdef MOOD_PRIORITY_EN
  localparam bit PRIO_ON = 1'b1;
`else
  localparam bit PRIO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [7:0]  action;
  logic [9:0]  nt_level;
  logic [14:0] nt3_level;
  logic [15:0] stimuli;
  logic [1:0]  stage;

  logic [7:0]  es, es3;
  logic [2:0]  dom, dom3;
  logic        dv, dv3, sc, sc3;

  always #5 clk = ~clk;

  mood_regulator #(.NT_W(2), .DWELL(4), .RELEASE(2)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .sample_en              (sample_en),
    .action                 (action),
    .neurotransmitter_level (nt_level),
    .stimuli                (stimuli),
    .development_stage      (stage),
    .emotional_state        (es),
    .dominant               (dom),
    .dominant_valid         (dv),
    .state_change           (sc)
  );

  mood_regulator #(.NT_W(3), .DWELL(1), .RELEASE(1)) dut3 (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .sample_en              (sample_en),
    .action                 (action),
    .neurotransmitter_level (nt3_level),
    .stimuli                (stimuli),
    .development_stage      (stage),
    .emotional_state        (es3),
    .dominant               (dom3),
    .dominant_valid         (dv3),
    .state_change           (sc3)
  );

  typedef struct {
    string      name;
    logic [9:0] nt;
    logic [15:0] stim;
    logic [1:0] stage;
    logic       asleep;
    logic [7:0] exp_state;
    logic [2:0] exp_dom;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] st;
    logic [2:0] dom;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Pack 2-bit levels in bus order {SER,NE,GABA,DOP,CORT}
  function automatic logic [9:0] nt2(input int ser, input int ne, input int gaba,
                                     input int dop, input int cort);
    return {ser[1:0], ne[1:0], gaba[1:0], dop[1:0], cort[1:0]};
  endfunction

  function automatic logic [14:0] nt3(input int ser, input int ne, input int gaba,
                                      input int dop, input int cort);
    return {ser[2:0], ne[2:0], gaba[2:0], dop[2:0], cort[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[14];
    exp_t item;

    vecs[0]  = '{"happy_bored_calm",     nt2(3,0,0,0,0), 16'h0000, 2'd3, 1'b0, 8'h51, 3'd0};
    vecs[1]  = '{"stressed_angry",       nt2(0,3,0,0,1), 16'h0000, 2'd3, 1'b0, 8'h24, 3'd2};
    vecs[2]  = '{"excited",              nt2(0,2,0,2,0), 16'h0000, 2'd3, 1'b0, 8'h02, 3'd1};
    vecs[3]  = '{"excited_nervous",      nt2(0,2,0,2,1), 16'h0000, 2'd3, 1'b0, 8'h0A, 3'd3};
    vecs[4]  = '{"apathetic",            nt2(0,0,0,0,2), 16'h3000, 2'd3, 1'b0, 8'h80, 3'd7};
    vecs[5]  = '{"starve_tired_no_stress", nt2(0,3,0,2,1), 16'h3000, 2'd3, 1'b0, 8'h02, 3'd1};
    vecs[6]  = '{"baby_stressed",        nt2(2,3,2,2,2), 16'h0000, 2'd0, 1'b0, 8'h04, 3'd2};
    vecs[7]  = '{"adult_not_stressed",   nt2(2,3,2,2,2), 16'h0000, 2'd3, 1'b0, 8'h00, 3'd0};
    vecs[8]  = '{"teen_angry",           nt2(2,2,2,0,0), 16'h0000, 2'd2, 1'b0, 8'h20, 3'd5};
    vecs[9]  = '{"child_not_angry",      nt2(2,2,2,0,0), 16'h0000, 2'd1, 1'b0, 8'h00, 3'd0};
    vecs[10] = '{"gaba_happy_calm",      nt2(0,1,2,0,1), 16'h0000, 2'd3, 1'b0, 8'h41, 3'd0};
    vecs[11] = '{"tired_bored",          nt2(0,1,2,0,1), 16'h2000, 2'd3, 1'b0, 8'h51, 3'd0};
    vecs[12] = '{"asleep_blocks_all",    nt2(3,0,0,0,0), 16'h0000, 2'd3, 1'b1, 8'h00, 3'd0};
    vecs[13] = '{"starving_only_stress", nt2(0,3,0,0,1), 16'h1000, 2'd3, 1'b0, 8'h24, 3'd2};

    rst_n     = 1'b0;
    sample_en = 1'b0;
    action    = 8'h00;
    nt_level  = '0;
    nt3_level = '0;
    stimuli   = 16'h0000;
    stage     = 2'd3;

    // Reset held while inputs toggle: every output stays 0
    for (int i = 0; i < 6; i++) begin
      nt_level  = 10'($urandom);
      nt3_level = 15'($urandom);
      stimuli   = 16'($urandom);
      sample_en = 1'($urandom);
      tick();
      check("reset_hold", {es[6:0] | es3[6:0], dv | dv3, 1'b0} | {es[7] | es3[7], sc | sc3, dom | dom3, 3'b000}, 8'h00);
    end
    $display("[TB] reset hold: state=%02h dom=%0d valid=%0b change=%0b", es, dom, dv, sc);

    // Release reset with happy inputs sampled every cycle
    nt_level  = nt2(3,0,0,0,0);
    nt3_level = '0;
    stimuli   = 16'h0000;
    action    = 8'h00;
    sample_en = 1'b1;
    rst_n     = 1'b1;
    repeat (DWELL - 1) tick();
    check("post_reset_dwell_minus_1", es, 8'h00);
    tick();
    check("post_reset_dwell", es, 8'h51);
    check("post_reset_change_pulse", 8'(sc), 8'h01);
    tick();
    check("post_reset_change_single", 8'(sc), 8'h00);
    check("post_reset_hold_on", es, 8'h51);
    $display("[TB] reset release: state=%02h after %0d samples", es, DWELL);

    // Asynchronous reset mid-operation, then a fresh dwell is needed
    #2 rst_n = 1'b0;
    #1 check("async_reset_clears", es, 8'h00);
    #1 rst_n = 1'b1;
    repeat (DWELL - 1) tick();
    check("async_reset_redwell_minus_1", es, 8'h00);
    tick();
    check("async_reset_redwell", es, 8'h51);
    $display("[TB] async reset: state=%02h", es);

    // Glitch: 3 happy samples then raw low never asserts
    action = 8'h01; sample_en = 1'b0; tick();
    action = 8'h00; sample_en = 1'b1;
    repeat (DWELL - 1) tick();
    nt_level = nt2(0,0,0,0,0);
    repeat (3) tick();
    check("glitch_rise_rejected", es, 8'h00);
    // With bit0 ON, a single low sample is absorbed
    nt_level = nt2(3,0,0,0,0);
    repeat (DWELL) tick();
    check("glitch_on", 8'(es[0]), 8'h01);
    nt_level = nt2(0,0,0,0,0); tick();
    check("glitch_falling_holds", 8'(es[0]), 8'h01);
    nt_level = nt2(3,0,0,0,0); tick();
    check("glitch_back_on", 8'(es[0]), 8'h01);
    nt_level = nt2(0,0,0,0,0); tick();
    check("release_1_of_2", 8'(es[0]), 8'h01);
    tick();
    check("release_2_of_2", 8'(es[0]), 8'h00);
    $display("[TB] glitch filter: state=%02h", es);

    // Sleep with stressed ON and happy RISING clears everything in one edge
    action = 8'h01; sample_en = 1'b0; tick();
    action = 8'h00; sample_en = 1'b1;
    nt_level = nt2(0,3,0,0,1);
    repeat (DWELL) tick();
    check("sleep_pre_stressed", es, 8'h24);
    nt_level = nt2(3,0,0,0,0); tick();
    check("sleep_pre_mixed", es, 8'h24);
    action = 8'h01; sample_en = 1'b0; tick();
    check("sleep_clear", es, 8'h00);
    check("sleep_change_pulse", 8'(sc), 8'h01);
    action = 8'h00;
    repeat (5) tick();
    check("no_sample_no_progress", es, 8'h00);
    sample_en = 1'b1;
    repeat (DWELL - 1) tick();
    check("wake_dwell_minus_1", es, 8'h00);
    tick();
    check("wake_dwell", es, 8'h51);
    $display("[TB] sleep override: state=%02h", es);

    // Classification table through the scoreboard
    foreach (vecs[i]) begin
      action    = 8'h01;
      sample_en = 1'b0;
      nt_level  = vecs[i].nt;
      stimuli   = vecs[i].stim;
      stage     = vecs[i].stage;
      tick();
      action    = {7'b0, vecs[i].asleep};
      sample_en = 1'b1;
      repeat (DWELL - 1) tick();
      check({vecs[i].name, "/dwell-1"}, es, 8'h00);
      sb_q.push_back('{vecs[i].name, vecs[i].exp_state, vecs[i].exp_dom});
      tick();
      item = sb_q.pop_front();
      check({item.name, "/state"}, es, item.st);
      check({item.name, "/valid"}, 8'(dv), 8'(item.st != 8'h00));
      check({item.name, "/change"}, 8'(sc), 8'(item.st != 8'h00));
      sample_en = 1'b0;
      tick();
      check({item.name, "/dominant"}, 8'(dom), 8'(PRIO_ON ? item.dom : 3'd0));
      check({item.name, "/change_done"}, 8'(sc), 8'h00);
      $display("[TB] vec %-24s nt=%03h stim=%04h stage=%0d sleep=%0b -> state=%02h dom=%0d",
               item.name, vecs[i].nt, vecs[i].stim, vecs[i].stage, vecs[i].asleep, es, dom);
    end

    // Wide levels (NT_W=3) with single-sample dwell and release
    action    = 8'h00;
    stimuli   = 16'h0000;
    stage     = 2'd3;
    sample_en = 1'b1;
    nt3_level = nt3(4,3,0,0,0);
    tick();
    check("nt3_ne011_is_lo", es3, 8'h51);
    check("nt3_dwell1_change", 8'(sc3), 8'h01);
    nt3_level = nt3(0,4,0,0,1);
    tick();
    check("nt3_ne100_hi_not_max", es3, 8'h28);
    sample_en = 1'b0;
    tick();
    check("nt3_dominant_angry", 8'(dom3), 8'(PRIO_ON ? 3'd5 : 3'd0));
    sample_en = 1'b1;
    nt3_level = nt3(0,7,0,0,1);
    tick();
    check("nt3_ne111_max_stressed", es3, 8'h24);
    sample_en = 1'b0;
    tick();
    check("nt3_dominant_stressed", 8'(dom3), 8'(PRIO_ON ? 3'd2 : 3'd0));
    $display("[TB] nt_w=3: state=%02h dom=%0d", es3, dom3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
